data_hazard_unit: RTL and testbench

Data-hazard/forwarding unit (DUHU) consuming the per-instruction operand-use flags produced by the ID-stage decoder. It keeps a registered scoreboard of the destinations of the instructions in EX, MEM and WB and uses it to generate forwarding selects for the three ID operands. It detects load-use hazards and, on one, stalls IF/ID for one cycle while injecting a bubble into EX. It also keeps a saturating stall counter for performance measurement.

---
 rtl/duhu_pkg.sv | 20 ++
 rtl/data_hazard_unit_fwd_select.sv | 35 +++
 rtl/data_hazard_unit.sv | 107 ++++++++++
 tb/tb_data_hazard_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/duhu_pkg.sv
// Shared types for the data-hazard/forwarding unit.
package duhu_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       le;
        logic       ld;
    } sb_slot_t;

    function automatic logic is_prod(sb_slot_t s, logic [4:0] r);
        return s.v && s.le && (s.rd == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/data_hazard_unit_fwd_select.sv
// Per-operand forwarding select and load-hit detection.
module fwd_select
    import duhu_pkg::*;
(
    input  logic       use_i,
    input  logic [4:0] r_i,
    input  sb_slot_t   ex_i,
    input  sb_slot_t   mem_i,
    input  sb_slot_t   wb_i,
    output logic [1:0] sel_o,
    output logic       ld_hit_o
);

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    assign hit_ex  = use_i && is_prod(ex_i, r_i);
    assign hit_mem = use_i && is_prod(mem_i, r_i);
    assign hit_wb  = use_i && is_prod(wb_i, r_i);

    // Youngest producer wins.
    always_comb begin
        sel_o = FWD_RF;
        priority case (1'b1)
            hit_ex:  sel_o = FWD_EX;
            hit_mem: sel_o = FWD_MEM;
            hit_wb:  sel_o = FWD_WB;
            default: sel_o = FWD_RF;
        endcase
    end

    assign ld_hit_o = hit_ex && ex_i.ld;

endmodule

// File: rtl/data_hazard_unit.sv
// Data-hazard/forwarding unit: EX/MEM/WB scoreboard, forwarding and load-use stall.
module data_hazard_unit
    import duhu_pkg::*;
#(
    parameter int FWD_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A_S_ID,
    input  logic             B_S_ID,
    input  logic             D_S_ID,
    input  logic             ID_NOP_ID,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic [4:0]       RD_ID,
    input  logic             RF_LE_ID,
    input  logic             L_ID,
    input  logic             FLUSH_ID,
    output logic [FWD_W-1:0] FWD_A,
    output logic [FWD_W-1:0] FWD_B,
    output logic [FWD_W-1:0] FWD_D,
    output logic             LE_IF,
    output logic             LE_ID,
    output logic             NOP_EX,
    output logic [CNT_W-1:0] STALL_CNT
);

    sb_slot_t         ex_q, ex_d;
    sb_slot_t         mem_q;
    sb_slot_t         wb_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       live;
    logic [1:0] sel_a, sel_b, sel_d;
    logic       hit_a, hit_b, hit_d;
    logic       stall;

    // Outputs are held at their idle values while reset is asserted.
    assign live = ~rst & ~ID_NOP_ID;

    fwd_select u_fwd_a (
        .use_i    (live & A_S_ID),
        .r_i      (RS1_ID),
        .ex_i     (ex_q),
        .mem_i    (mem_q),
        .wb_i     (wb_q),
        .sel_o    (sel_a),
        .ld_hit_o (hit_a)
    );

    fwd_select u_fwd_b (
        .use_i    (live & B_S_ID),
        .r_i      (RS2_ID),
        .ex_i     (ex_q),
        .mem_i    (mem_q),
        .wb_i     (wb_q),
        .sel_o    (sel_b),
        .ld_hit_o (hit_b)
    );

    fwd_select u_fwd_d (
        .use_i    (live & D_S_ID),
        .r_i      (RD_ID),
        .ex_i     (ex_q),
        .mem_i    (mem_q),
        .wb_i     (wb_q),
        .sel_o    (sel_d),
        .ld_hit_o (hit_d)
    );

    assign stall  = (hit_a | hit_b | hit_d) & ~FLUSH_ID;
    assign LE_IF  = ~stall;
    assign LE_ID  = ~stall;
    assign NOP_EX = ~rst & (stall | FLUSH_ID);
    assign FWD_A  = FWD_W'(sel_a);
    assign FWD_B  = FWD_W'(sel_b);
    assign FWD_D  = FWD_W'(sel_d);
    assign STALL_CNT = cnt_q;

    always_comb begin
        ex_d = '0;
        if (!(ID_NOP_ID | stall | FLUSH_ID)) begin
            ex_d.v  = 1'b1;
            ex_d.rd = RD_ID;
            ex_d.le = RF_LE_ID;
            ex_d.ld = L_ID;
        end
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_data_hazard_unit.sv
// Directed bench for data_hazard_unit with an expected-value queue.
module tb_data_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       A_S_ID, B_S_ID, D_S_ID, ID_NOP_ID;
    logic [4:0] RS1_ID, RS2_ID, RD_ID;
    logic       RF_LE_ID, L_ID, FLUSH_ID;

    logic [1:0]  FWD_A, FWD_B, FWD_D, FWD_A2, FWD_B2, FWD_D2;
    logic        LE_IF, LE_ID, NOP_EX, LE_IF2, LE_ID2, NOP_EX2;
    logic [15:0] STALL_CNT;
    logic [1:0]  STALL_CNT2;

    int checks = 0;
    int errors = 0;
    int n = 0;

    typedef struct {
        string      tag;
        logic [1:0] fa, fb, fd;
        bit         chkf;
        logic       le, nop;
        logic [15:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    data_hazard_unit #(.FWD_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .A_S_ID(A_S_ID), .B_S_ID(B_S_ID), .D_S_ID(D_S_ID),
        .ID_NOP_ID(ID_NOP_ID),
        .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .RD_ID(RD_ID),
        .RF_LE_ID(RF_LE_ID), .L_ID(L_ID), .FLUSH_ID(FLUSH_ID),
        .FWD_A(FWD_A), .FWD_B(FWD_B), .FWD_D(FWD_D),
        .LE_IF(LE_IF), .LE_ID(LE_ID), .NOP_EX(NOP_EX),
        .STALL_CNT(STALL_CNT)
    );

    data_hazard_unit #(.FWD_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .A_S_ID(A_S_ID), .B_S_ID(B_S_ID), .D_S_ID(D_S_ID),
        .ID_NOP_ID(ID_NOP_ID),
        .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .RD_ID(RD_ID),
        .RF_LE_ID(RF_LE_ID), .L_ID(L_ID), .FLUSH_ID(FLUSH_ID),
        .FWD_A(FWD_A2), .FWD_B(FWD_B2), .FWD_D(FWD_D2),
        .LE_IF(LE_IF2), .LE_ID(LE_ID2), .NOP_EX(NOP_EX2),
        .STALL_CNT(STALL_CNT2)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set(input logic nop, input logic a_s, input logic [4:0] rs1,
                       input logic b_s, input logic [4:0] rs2,
                       input logic d_s, input logic [4:0] rd,
                       input logic le, input logic ld, input logic flush);
        ID_NOP_ID = nop;
        A_S_ID = a_s; RS1_ID = rs1;
        B_S_ID = b_s; RS2_ID = rs2;
        D_S_ID = d_s; RD_ID = rd;
        RF_LE_ID = le; L_ID = ld; FLUSH_ID = flush;
    endtask

    // Called 1 time unit after a rising edge; checks at the falling edge.
    task automatic step(input string tag, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [1:0] fd,
                        input bit chkf, input bit stl);
        exp_t e;
        e.tag  = tag;
        e.fa   = fa; e.fb = fb; e.fd = fd;
        e.chkf = chkf;
        e.le   = !stl;
        e.nop  = !rst && (stl || FLUSH_ID);
        e.cnt  = 16'(n);
        e.cnt2 = (n > 3) ? 2'd3 : 2'(n);
        q.push_back(e);
        #4;
        e = q.pop_front();
        if (e.chkf) begin
            chk({e.tag, ".fwd_a"}, 16'(FWD_A), 16'(e.fa));
            chk({e.tag, ".fwd_b"}, 16'(FWD_B), 16'(e.fb));
            chk({e.tag, ".fwd_d"}, 16'(FWD_D), 16'(e.fd));
        end
        chk({e.tag, ".le_if"}, 16'(LE_IF), 16'(e.le));
        chk({e.tag, ".le_id"}, 16'(LE_ID), 16'(e.le));
        chk({e.tag, ".nop_ex"}, 16'(NOP_EX), 16'(e.nop));
        chk({e.tag, ".cnt"}, STALL_CNT, e.cnt);
        chk({e.tag, ".cnt2"}, 16'(STALL_CNT2), 16'(e.cnt2));
        @(posedge clk);
        #1;
        if (rst) n = 0;
        else if (stl) n++;
    endtask

    initial begin
        rst = 1'b1;
        set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        step("reset", 0, 0, 0, 1, 0);
        rst = 1'b0;
        step("post_reset", 0, 0, 0, 1, 0);

        // ALU r3 then rs1 use
        set(0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
        step("alu3_issue", 0, 0, 0, 1, 0);
        set(0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        step("fwd_a_ex", 1, 0, 0, 1, 0);

        // two producers of r5
        set(0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
        step("p5_first", 0, 0, 0, 1, 0);
        step("p5_second", 0, 0, 0, 1, 0);
        set(0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        step("ex_over_mem", 0, 1, 0, 1, 0);
        step("fwd_b_mem", 0, 2, 0, 1, 0);

        // WB forwarding on rd operand
        set(0, 0, 0, 0, 0, 0, 13, 1, 0, 0);
        step("p13_issue", 0, 0, 0, 1, 0);
        set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle_a", 0, 0, 0, 1, 0);
        step("idle_b", 0, 0, 0, 1, 0);
        set(0, 0, 0, 0, 0, 1, 13, 0, 0, 0);
        step("fwd_d_wb", 0, 0, 3, 1, 0);
        set(0, 0, 0, 0, 0, 0, 14, 1, 0, 0);
        step("p14_issue", 0, 0, 0, 1, 0);
        set(0, 0, 0, 0, 0, 1, 14, 0, 0, 0);
        step("fwd_d_ex", 0, 0, 1, 1, 0);

        // load-use on store data
        set(0, 0, 0, 0, 0, 0, 7, 1, 1, 0);
        step("ld7_issue", 0, 0, 0, 1, 0);
        set(0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        step("ld_use_stall", 0, 0, 0, 0, 1);
        step("ld_use_fwd", 0, 2, 0, 1, 0);

        // r0 never forwards
        set(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("p0_issue", 0, 0, 0, 1, 0);
        set(0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        step("r0_use", 0, 0, 0, 1, 0);

        // bubble in ID ignores matching EX load
        set(0, 0, 0, 0, 0, 0, 9, 1, 1, 0);
        step("ld9_issue", 0, 0, 0, 1, 0);
        set(1, 1, 9, 1, 9, 0, 0, 0, 0, 0);
        step("id_nop", 0, 0, 0, 1, 0);

        // flush beats stall
        set(0, 0, 0, 0, 0, 0, 4, 1, 1, 0);
        step("ld4_issue", 0, 0, 0, 1, 0);
        set(0, 1, 4, 0, 0, 0, 0, 0, 0, 1);
        step("flush", 0, 0, 0, 0, 0);
        set(0, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        step("post_flush", 2, 0, 0, 1, 0);

        // three independent load-use pairs
        for (int i = 0; i < 3; i++) begin
            set(0, 0, 0, 0, 0, 0, 20, 1, 1, 0);
            step("ld20_issue", 0, 0, 0, 1, 0);
            set(0, 1, 20, 0, 0, 0, 0, 0, 0, 0);
            step("ld20_stall", 0, 0, 0, 0, 1);
            step("ld20_fwd", 2, 0, 0, 1, 0);
        end

        // chained loads: each dependent pair stalls once
        set(0, 0, 0, 0, 0, 0, 21, 1, 1, 0);
        step("ld21_issue", 0, 0, 0, 1, 0);
        set(0, 0, 0, 1, 21, 0, 22, 1, 1, 0);
        step("ld22_stall", 0, 0, 0, 0, 1);
        step("ld22_issue", 0, 2, 0, 1, 0);
        set(0, 1, 22, 0, 0, 0, 0, 0, 0, 0);
        step("use22_stall", 0, 0, 0, 0, 1);
        step("use22_fwd", 2, 0, 0, 1, 0);
        set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("cnt_sat", 0, 0, 0, 1, 0);
        chk("cnt_total", STALL_CNT, 16'd6);
        chk("cnt_saturated", 16'(STALL_CNT2), 16'd3);

        // reset while a load-use hazard is pending
        set(0, 0, 0, 0, 0, 0, 6, 1, 1, 0);
        step("ld6_issue", 0, 0, 0, 1, 0);
        set(0, 1, 6, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step("rst_mid_stall", 0, 0, 0, 1, 0);
        rst = 1'b0;
        step("after_rst", 0, 0, 0, 1, 0);
        chk("rst_cnt", STALL_CNT, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
